// File: rtl/probe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : probe_pkg
// Brief    : Shared field widths, probe page layout and page-field struct for
//            the probe page display controller.
// Revision : 1.0 - initial release
// ============================================================================
package probe_pkg;

   // Width of one display field (one dualseg7 pair or the LED byte)
   localparam int FIELD_W   = 8;

   // One probe page is 32 bits: right, middle, left, led from LSB upward
   localparam int PAGE_BITS = 32;
   localparam int RIGHT_LSB = 0;
   localparam int MID_LSB   = 8;
   localparam int LEFT_LSB  = 16;
   localparam int LED_LSB   = 24;

   typedef struct packed {
      logic [FIELD_W-1:0] led;
      logic [FIELD_W-1:0] left;
      logic [FIELD_W-1:0] mid;
      logic [FIELD_W-1:0] right;
   } page_fields_t;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Brief    : Two-flop synchroniser, counting debouncer and one-cycle press
//            pulse for an active-low push-button. Release gives no pulse.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_n,
   output logic press
);

   // DEBOUNCE_CYCLES >= 2, so this is at least 1 bit and holds DEBOUNCE_CYCLES-1
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_db;
   logic             r_db_prev;
   logic             r_press;
   logic [CNT_W-1:0] r_cnt;
   logic             w_mismatch;
   logic             w_flip;

   assign w_mismatch = r_sync2 ^ r_db;
   assign w_flip     = w_mismatch && (r_cnt == C_CNT_LAST);
   assign press      = r_press;

   // Bring the raw button into the clock domain; idle state is released (1)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= btn_n;
         r_sync2 <= r_sync1;
      end
   end

   // Count consecutive disagreeing samples; flip the debounced state once enough have been seen
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
         r_db  <= 1'b1;
      end else if (!w_mismatch) begin
         r_cnt <= '0;
      end else if (w_flip) begin
         r_cnt <= '0;
         r_db  <= ~r_db;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // One-cycle pulse the cycle after the debounced state falls (press, not release)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_db_prev <= 1'b1;
         r_press   <= 1'b0;
      end else begin
         r_db_prev <= r_db;
         r_press   <= r_db_prev & ~r_db;
      end
   end

endmodule
`default_nettype wire

// File: rtl/probe_page_display.sv
`default_nettype none
// ============================================================================
// Module   : probe_page_display
// Brief    : N-page debug display controller. A debounced button (and an
//            optional timed scroll) selects one 32-bit probe page, whose
//            fields are latched onto the left/middle/right hex bytes and LEDs.
//            A freeze input holds the displayed values.
// Options  : PROBE_AUTOSCROLL_EN - build the timed auto-scroll counter.
// Revision : 1.0 - initial release
// ============================================================================
module probe_page_display
   import probe_pkg::*;
#(
   parameter  int NUM_PAGES       = 4,
   parameter  int DEBOUNCE_CYCLES = 50000,
   parameter  int SCROLL_CYCLES   = 50000000,
   localparam int PAGE_W          = ($clog2(NUM_PAGES) > 1) ? $clog2(NUM_PAGES) : 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           page_btn_n,
   input  logic                           freeze,
   input  logic                           autoscroll,
   input  logic [NUM_PAGES*PAGE_BITS-1:0] probe,
   output logic [FIELD_W-1:0]             left_hex,
   output logic [FIELD_W-1:0]             middle_hex,
   output logic [FIELD_W-1:0]             right_hex,
   output logic [9:0]                     ledr,
   output logic [PAGE_W-1:0]              page
);

   localparam logic [PAGE_W-1:0] C_PAGE_LAST = PAGE_W'(NUM_PAGES - 1);

   logic                 w_press;
   logic                 w_scroll_tick;
   logic                 w_advance;
   logic [PAGE_BITS-1:0] w_word;
   page_fields_t         w_fields;
   logic [PAGE_W-1:0]    r_page;
   logic [FIELD_W-1:0]   r_left;
   logic [FIELD_W-1:0]   r_mid;
   logic [FIELD_W-1:0]   r_right;
   logic [FIELD_W-1:0]   r_led;
   logic                 r_freeze_led;
   logic                 r_page_led;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn (
      .clk   (clk),
      .reset (reset),
      .btn_n (page_btn_n),
      .press (w_press)
   );

`ifdef PROBE_AUTOSCROLL_EN
   localparam int SCROLL_W = $clog2(SCROLL_CYCLES);
   localparam logic [SCROLL_W-1:0] C_SCROLL_LAST = SCROLL_W'(SCROLL_CYCLES - 1);

   logic [SCROLL_W-1:0] r_scroll_cnt;

   assign w_scroll_tick = autoscroll && !freeze && (r_scroll_cnt == C_SCROLL_LAST);

   // Dwell timer; a manual press restarts the dwell so the operator gets a full period
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_scroll_cnt <= '0;
      end else if (!autoscroll || freeze || w_press || w_scroll_tick) begin
         r_scroll_cnt <= '0;
      end else begin
         r_scroll_cnt <= r_scroll_cnt + SCROLL_W'(1);
      end
   end
`else
   logic w_unused_autoscroll;

   assign w_unused_autoscroll = autoscroll;
   assign w_scroll_tick       = 1'b0;
`endif

   // Coincident press and scroll tick collapse into a single step
   assign w_advance = w_press | w_scroll_tick;

   // Page index, wrapping at the last page; keeps moving even while frozen
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_page <= '0;
      end else if (w_advance) begin
         r_page <= (r_page == C_PAGE_LAST) ? '0 : r_page + PAGE_W'(1);
      end
   end

   // Select the probe word of the current page
   always_comb begin
      w_word = '0;
      for (int i = 0; i < NUM_PAGES; i++) begin
         if (r_page == PAGE_W'(i)) begin
            w_word = probe[i*PAGE_BITS +: PAGE_BITS];
         end
      end
   end

   // Split the selected word into its display fields
   always_comb begin
      w_fields       = '0;
      w_fields.right = w_word[RIGHT_LSB +: FIELD_W];
      w_fields.mid   = w_word[MID_LSB   +: FIELD_W];
      w_fields.left  = w_word[LEFT_LSB  +: FIELD_W];
      w_fields.led   = w_word[LED_LSB   +: FIELD_W];
   end

   // Display snapshot registers hold under freeze; status LEDs always track
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_left       <= '0;
         r_mid        <= '0;
         r_right      <= '0;
         r_led        <= '0;
         r_freeze_led <= 1'b0;
         r_page_led   <= 1'b0;
      end else begin
         r_freeze_led <= freeze;
         r_page_led   <= r_page[0];
         if (!freeze) begin
            r_left  <= w_fields.left;
            r_mid   <= w_fields.mid;
            r_right <= w_fields.right;
            r_led   <= w_fields.led;
         end
      end
   end

   assign left_hex   = r_left;
   assign middle_hex = r_mid;
   assign right_hex  = r_right;
   assign ledr       = {r_page_led, r_freeze_led, r_led};
   assign page       = r_page;

endmodule
`default_nettype wire

// File: doc/probe_page_display.md
# probe_page_display

Parametrised page-selecting debug display controller for the UP3 processor board harness. It sits between the processor's debug signals and the three `dualseg7` display pairs plus LEDR. It latches one of NUM_PAGES probe pages onto the left, middle and right byte fields and the LED byte. Pages are selected by a debounced push-button, with optional timed auto-scroll and a freeze/snapshot control. It generalises the fixed two-view KEY[3] multiplexing into a clocked, N-page monitor.

## Interface
Parameters:
- NUM_PAGES, 4: number of probe pages, legal range 2..16.
- DEBOUNCE_CYCLES, 50000: consecutive stable samples required before the debounced button state changes; minimum 2.
- SCROLL_CYCLES, 50000000: auto-scroll dwell per page in clock cycles; minimum 2.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  asynchronous, active-high reset.
- page_btn_n  in  1  raw active-low push-button (KEY); asynchronous to clk.
- freeze  in  1  high = hold displayed values (snapshot).
- autoscroll  in  1  high = timed page advance (used only when PROBE_AUTOSCROLL_EN is defined).
- probe  in  NUM_PAGES*32  page p = probe[p*32 +: 32]: [7:0] right, [15:8] middle, [23:16] left, [31:24] led.
- left_hex  out  8  to left `dualseg7`.
- middle_hex  out  8  to middle `dualseg7`.
- right_hex  out  8  to right `dualseg7`.
- ledr  out  10  [7:0] page led byte, [8] freeze active, [9] page index bit 0.
- page  out  PAGE_W  current page index; PAGE_W = max(1, $clog2(NUM_PAGES)).

## Operation
- Synchroniser: page_btn_n passes through a 2-flop synchroniser that resets to 1 (released).
- Debounce: the counter increments each cycle the synced value differs from the debounced state and clears to 0 on any cycle they match. When the count reaches DEBOUNCE_CYCLES-1 while still mismatched, the debounced state flips and the counter clears. Debounced state resets to 1.
- press: a registered one-cycle pulse in the cycle after the debounced state goes 1→0. Release generates no pulse. Holding the button produces exactly one press.
- Page counter: increments on advance = press OR scroll_tick, and wraps NUM_PAGES-1 → 0. A press and a scroll_tick in the same cycle give a single increment. The counter keeps advancing while freeze=1.
- Display registers (left_hex, middle_hex, right_hex, ledr[7:0]) load the fields of probe page `page` every cycle while freeze=0 and hold while freeze=1.
- ledr[8] and ledr[9] are registered copies of freeze and page[0]; they update every cycle regardless of freeze.
- Releasing freeze: the display shows the then-current page on the next edge.
- Reset values: page=0, all display registers 0, ledr=0, press=0, all counters 0.

## Timing
- Display latency: probe change → outputs update on the next clk edge (1 cycle).
- Button latency: the first raw low sample reaches the debounced flip after 2 + DEBOUNCE_CYCLES edges. press is asserted 1 edge later, page changes 1 edge after that, and the display changes 1 edge after that. Total: DEBOUNCE_CYCLES+5 edges.
- Glitches shorter than DEBOUNCE_CYCLES synced cycles produce no press.
- Reset asserted mid-debounce or mid-scroll clears everything immediately (asynchronously). After deassertion, a still-held button must satisfy a full debounce before it counts, and then produces one press.

## Configuration
- PROBE_AUTOSCROLL_EN defined:
  - A scroll counter runs while autoscroll=1 and freeze=0, and asserts scroll_tick for one cycle when it reaches SCROLL_CYCLES-1, then clears.
  - The counter clears when autoscroll=0, when freeze=1, and on press, so a manual press restarts the dwell period.
- PROBE_AUTOSCROLL_EN undefined: no scroll counter is built, scroll_tick is tied to 0, and the autoscroll port is present but ignored.

## Structure
- Package probe_pkg holds FIELD_W=8, the PAGE_BITS=32 page layout offsets (RIGHT_LSB=0, MID_LSB=8, LEFT_LSB=16, LED_LSB=24) and a page-field struct typedef.
- One sub-module: btn_debounce (synchroniser + debounce + press pulse), parametrised by DEBOUNCE_CYCLES.
- Top-level board wrapper instantiates probe_page_display with three `dualseg7` instances.

## Test plan
Bench parameters: NUM_PAGES=3, DEBOUNCE_CYCLES=4, SCROLL_CYCLES=10. Page p probe = {8'hL_p, 8'hA_p, 8'hB_p, 8'hC_p} with distinct bytes.
- Reset: outputs are 0 during reset; the first edge after release gives left_hex/middle_hex/right_hex = page 0 bytes, page=0.
- Clean press: page_btn_n held low for 20 cycles → exactly one press, page=1, and the display shows page 1 bytes 9 edges after the first low sample. Release gives no change.
- Glitch plus wrap: a 3-cycle low pulse causes no page change. Then three clean presses give page 1→2→0, and ledr[9] follows page[0].
- Freeze: freeze=1, then change probe page-0 bytes and press once → outputs hold old values, page=1, ledr[8]=1. freeze=0 → page 1 bytes on the next edge.
- Auto-scroll (macro defined): autoscroll=1 → page advances every 10 cycles. A press at cycle 5 gives a single increment and restarts the dwell, so the next advance comes 10 cycles later. Macro undefined: no advance.
- Reset mid-debounce: assert reset with the button held low at debounce count 2 → after deassertion, one press after the full debounce and no double count.
